// File: rtl/dcache_controller.sv
// Direct-mapped, write-back, write-allocate data cache between the MEM stage and
// off-chip memory. Hits complete combinationally; misses stall the pipeline.
module dcache_controller #(
    parameter int NUM_LINES = 32,
    parameter int BLOCK_W   = 256
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic [31:0]        p1_addr_i,
    input  logic [31:0]        p1_data_i,
    input  logic               p1_MemRead_i,
    input  logic               p1_MemWrite_i,
    output logic [31:0]        p1_data_o,
    output logic               p1_stall_o,
    input  logic [BLOCK_W-1:0] mem_data_i,
    input  logic               mem_ack_i,
    output logic [BLOCK_W-1:0] mem_data_o,
    output logic [31:0]        mem_addr_o,
    output logic               mem_enable_o,
    output logic               mem_write_o
);
    localparam int OFF_W  = $clog2(BLOCK_W / 8);
    localparam int WSEL_W = OFF_W - 2;
    localparam int IDX_W  = $clog2(NUM_LINES);
    localparam int TAG_W  = 32 - OFF_W - IDX_W;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        WRITEBACK = 2'd1,
        ALLOCATE  = 2'd2,
        FILLED    = 2'd3
    } state_t;

    state_t               state_r, state_s;
    logic [NUM_LINES-1:0] valid_r, dirty_r;
    logic [TAG_W-1:0]     tag_r  [NUM_LINES];
    logic [BLOCK_W-1:0]   data_r [NUM_LINES];
    logic [TAG_W-1:0]     miss_tag_r;
    logic [IDX_W-1:0]     miss_idx_r;
    logic                 mem_enable_r, mem_write_r;
    logic [31:0]          mem_addr_r;
    logic [BLOCK_W-1:0]   mem_data_r;

    logic [TAG_W-1:0]     tag_s;
    logic [IDX_W-1:0]     idx_s;
    logic [WSEL_W-1:0]    wsel_s;
    logic                 req_s, hit_s, rd_hit_s, wr_hit_s, fill_s, fill_conflict_s, victim_dirty_s;
    logic                 unused_addr_s;

    assign tag_s           = p1_addr_i[31 -: TAG_W];
    assign idx_s           = p1_addr_i[OFF_W +: IDX_W];
    assign wsel_s          = p1_addr_i[2 +: WSEL_W];
    assign unused_addr_s   = ^p1_addr_i[1:0];
    assign req_s           = p1_MemRead_i | p1_MemWrite_i;
    assign hit_s           = valid_r[idx_s] && (tag_r[idx_s] == tag_s);
    // A simultaneous read+write request is a store.
    assign rd_hit_s        = p1_MemRead_i & ~p1_MemWrite_i & hit_s;
    assign wr_hit_s        = p1_MemWrite_i & hit_s;
    assign victim_dirty_s  = valid_r[idx_s] & dirty_r[idx_s];
    assign fill_s          = (state_r == ALLOCATE) && mem_ack_i;
    assign fill_conflict_s = fill_s && (idx_s == miss_idx_r);

    assign p1_stall_o   = req_s & ~hit_s;
    assign mem_enable_o = mem_enable_r;
    assign mem_write_o  = mem_write_r;
    assign mem_addr_o   = mem_addr_r;
    assign mem_data_o   = mem_data_r;

    // Zero-latency load data on a read hit.
    always_comb begin
        p1_data_o = 32'd0;
        if (rd_hit_s) begin
            p1_data_o = data_r[idx_s][{wsel_s, 5'd0} +: 32];
        end else begin
            p1_data_o = 32'd0;
        end
    end

    // Miss-handling state register.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Next-state logic; acks outside WRITEBACK/ALLOCATE fall through unused.
    always_comb begin
        state_s = state_r;
        case (state_r)
            IDLE: begin
                if (req_s && !hit_s) begin
                    state_s = victim_dirty_s ? WRITEBACK : ALLOCATE;
                end else begin
                    state_s = IDLE;
                end
            end
            WRITEBACK: begin
                if (mem_ack_i) begin
                    state_s = ALLOCATE;
                end else begin
                    state_s = WRITEBACK;
                end
            end
            ALLOCATE: begin
                if (mem_ack_i) begin
                    state_s = FILLED;
                end else begin
                    state_s = ALLOCATE;
                end
            end
            FILLED:  state_s = IDLE;
            default: state_s = IDLE;
        endcase
    end

    // Memory request registers: loaded at miss detection, held for the whole transaction.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            mem_enable_r <= 1'b0;
            mem_write_r  <= 1'b0;
            mem_addr_r   <= 32'd0;
            mem_data_r   <= {BLOCK_W{1'b0}};
            miss_tag_r   <= {TAG_W{1'b0}};
            miss_idx_r   <= {IDX_W{1'b0}};
        end else begin
            case (state_r)
                IDLE: begin
                    if (req_s && !hit_s) begin
                        miss_tag_r   <= tag_s;
                        miss_idx_r   <= idx_s;
                        mem_enable_r <= 1'b1;
                        mem_data_r   <= data_r[idx_s];
                        mem_write_r  <= victim_dirty_s;
                        mem_addr_r   <= victim_dirty_s ? {tag_r[idx_s], idx_s, {OFF_W{1'b0}}}
                                                       : {tag_s, idx_s, {OFF_W{1'b0}}};
                    end
                end
                WRITEBACK: begin
                    if (mem_ack_i) begin
                        mem_write_r <= 1'b0;
                        mem_addr_r  <= {miss_tag_r, miss_idx_r, {OFF_W{1'b0}}};
                    end
                end
                ALLOCATE: begin
                    if (mem_ack_i) begin
                        mem_enable_r <= 1'b0;
                        mem_write_r  <= 1'b0;
                    end
                end
                FILLED:  mem_enable_r <= 1'b0;
                default: mem_enable_r <= 1'b0;
            endcase
        end
    end

    // Valid/dirty bookkeeping; a refill wins over a store to the same line.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            valid_r <= {NUM_LINES{1'b0}};
            dirty_r <= {NUM_LINES{1'b0}};
        end else begin
            if (fill_s) begin
                valid_r[miss_idx_r] <= 1'b1;
                dirty_r[miss_idx_r] <= 1'b0;
            end
            if (wr_hit_s && !fill_conflict_s) begin
                dirty_r[idx_s] <= 1'b1;
            end
        end
    end

    // Tag and data arrays carry no reset; valid bits qualify their contents.
    always_ff @(posedge clk_i) begin
        if (fill_s) begin
            data_r[miss_idx_r] <= mem_data_i;
            tag_r[miss_idx_r]  <= miss_tag_r;
        end
        if (wr_hit_s && !fill_conflict_s) begin
            data_r[idx_s][{wsel_s, 5'd0} +: 32] <= p1_data_i;
        end
    end
endmodule

// File: tb/tb_dcache_controller.sv
// Scoreboard bench for dcache_controller: a flat golden memory predicts load data,
// a line-indexed tag model predicts stall lengths, and a memory model answers requests.
module tb_dcache_controller;
    logic         clk_i = 1'b0;
    logic         rst_i;
    logic [31:0]  p1_addr_i, p1_data_i, p1_data_o, mem_addr_o;
    logic         p1_MemRead_i, p1_MemWrite_i, p1_stall_o, mem_ack_i, mem_enable_o, mem_write_o;
    logic [255:0] mem_data_i, mem_data_o;

    always #5 clk_i = ~clk_i;

    dcache_controller dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .p1_addr_i(p1_addr_i), .p1_data_i(p1_data_i),
        .p1_MemRead_i(p1_MemRead_i), .p1_MemWrite_i(p1_MemWrite_i),
        .p1_data_o(p1_data_o), .p1_stall_o(p1_stall_o),
        .mem_data_i(mem_data_i), .mem_ack_i(mem_ack_i),
        .mem_data_o(mem_data_o), .mem_addr_o(mem_addr_o),
        .mem_enable_o(mem_enable_o), .mem_write_o(mem_write_o)
    );

    int checks = 0;
    int errors = 0;
    int mem_lat = 4;
    int rst_epoch = 0;
    int rd_count = 0;
    int wb_count = 0;
    logic [31:0]  last_rd_addr = 32'd0;
    logic [31:0]  last_wb_addr = 32'd0;
    logic [255:0] last_wb_data = 256'd0;
    logic [31:0]  exp_q[$];
    logic [31:0]  golden [logic [31:0]];
    logic [255:0] offchip [logic [31:0]];
    bit           m_valid [32];
    bit           m_dirty [32];
    logic [21:0]  m_tag [32];

    function automatic logic [31:0] pattern(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
    endfunction

    function automatic logic [255:0] offchip_line(input logic [31:0] la);
        logic [255:0] l;
        if (offchip.exists(la)) return offchip[la];
        for (int w = 0; w < 8; w++) l[w*32 +: 32] = pattern(la + 32'(w * 4));
        return l;
    endfunction

    function automatic logic [31:0] golden_word(input logic [31:0] wa);
        if (golden.exists(wa)) return golden[wa];
        return pattern(wa);
    endfunction

    task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // After a reset the cache forgets dirty data: architectural memory is what off-chip holds.
    task automatic reset_model();
        logic [255:0] l;
        for (int i = 0; i < 32; i++) begin
            m_valid[i] = 1'b0;
            m_dirty[i] = 1'b0;
        end
        foreach (golden[k]) begin
            l = offchip_line({k[31:5], 5'd0});
            golden[k] = l[{k[4:2], 5'd0} +: 32];
        end
        exp_q.delete();
        rst_epoch++;
    endtask

    // Scoreboard monitor: every completed load is compared with the oldest expectation.
    always @(negedge clk_i) begin
        if (!rst_i && p1_MemRead_i && !p1_MemWrite_i && !p1_stall_o) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL load_unexpected: got %h expected none", p1_data_o);
            end else begin
                check("load_data", 256'(p1_data_o), 256'(exp_q.pop_front()));
            end
        end
    end

    // Off-chip memory: acks mem_lat cycles after a request appears.
    initial begin
        mem_ack_i  = 1'b0;
        mem_data_i = 256'd0;
        @(posedge clk_i); #1;
        forever begin
            if (mem_enable_o && !rst_i) begin : tx
                logic [31:0]  a;
                logic         w;
                logic [255:0] d;
                int           ep;
                int           lat;
                a = mem_addr_o; w = mem_write_o; d = mem_data_o; ep = rst_epoch; lat = mem_lat;
                repeat (lat) @(posedge clk_i);
                #1;
                if (ep == rst_epoch) begin
                    check("mem_addr_stable", 256'(mem_addr_o), 256'(a));
                    check("mem_write_stable", 256'(mem_write_o), 256'(w));
                    if (w) check("mem_data_stable", mem_data_o, d);
                end
                if (!w) mem_data_i = offchip_line(a);
                mem_ack_i = 1'b1;
                if (ep == rst_epoch) begin
                    if (w) begin
                        for (int k = 0; k < 8; k++)
                            check("wb_data", 256'(d[k*32 +: 32]), 256'(golden_word(a + 32'(k * 4))));
                        offchip[a] = d;
                        last_wb_addr = a;
                        last_wb_data = d;
                        wb_count++;
                    end else begin
                        last_rd_addr = a;
                        rd_count++;
                    end
                end
                @(posedge clk_i); #1;
                mem_ack_i  = 1'b0;
                mem_data_i = 256'd0;
            end else begin
                @(posedge clk_i); #1;
            end
        end
    end

    // One CPU access: predicts stall length and load data, then holds the request until it completes.
    task automatic access(input logic [31:0] addr, input logic [31:0] wdata, input bit rd, input bit wr);
        int          idx;
        logic [21:0] tg;
        bit          hit;
        int          exp_stall;
        int          cyc;
        idx = int'(addr[9:5]);
        tg  = addr[31:10];
        hit = m_valid[idx] && (m_tag[idx] == tg);
        if (hit) exp_stall = 0;
        else if (m_valid[idx] && m_dirty[idx]) exp_stall = 2 * mem_lat + 3;
        else exp_stall = mem_lat + 2;
        if (rd && !wr) exp_q.push_back(golden_word({addr[31:2], 2'b00}));
        p1_addr_i = addr; p1_data_i = wdata; p1_MemRead_i = rd; p1_MemWrite_i = wr;
        cyc = 0;
        forever begin
            @(negedge clk_i);
            if (!p1_stall_o) break;
            cyc++;
            if (cyc > 200) break;
        end
        check("stall_cycles", 256'(cyc), 256'(exp_stall));
        @(posedge clk_i); #1;
        p1_MemRead_i = 1'b0; p1_MemWrite_i = 1'b0;
        if (!hit) begin
            m_valid[idx] = 1'b1; m_tag[idx] = tg; m_dirty[idx] = 1'b0;
        end
        if (wr) begin
            m_dirty[idx] = 1'b1;
            golden[{addr[31:2], 2'b00}] = wdata;
        end
    endtask

    initial begin
        logic [255:0] l;
        int           cyc;
        rst_i = 1'b1; p1_addr_i = 32'd0; p1_data_i = 32'd0; p1_MemRead_i = 1'b0; p1_MemWrite_i = 1'b0;
        reset_model();
        repeat (2) @(posedge clk_i);
        #1;
        check("rst_mem_enable", 256'(mem_enable_o), 256'(0));
        check("rst_mem_write", 256'(mem_write_o), 256'(0));
        check("rst_mem_addr", 256'(mem_addr_o), 256'(0));
        check("rst_mem_data", mem_data_o, 256'(0));
        check("rst_stall", 256'(p1_stall_o), 256'(0));
        check("rst_data", 256'(p1_data_o), 256'(0));
        rst_i = 1'b0;
        @(posedge clk_i); #1;

        // Cold load with a known first word, 4-cycle memory.
        l = offchip_line(32'h40);
        l[31:0] = 32'h1234_5678;
        offchip[32'h40] = l;
        golden[32'h40] = 32'h1234_5678;
        mem_lat = 4;
        access(32'h40, 32'd0, 1'b1, 1'b0);
        check("cold_rd_addr", 256'(last_rd_addr), 256'(32'h40));
        check("cold_rd_count", 256'(rd_count), 256'(1));
        check("cold_no_wb", 256'(wb_count), 256'(0));

        // Store hit, reload, then idle output is zero.
        access(32'h44, 32'hDEAD_BEEF, 1'b0, 1'b1);
        access(32'h44, 32'd0, 1'b1, 1'b0);
        @(negedge clk_i);
        check("idle_data_zero", 256'(p1_data_o), 256'(0));
        @(posedge clk_i); #1;

        // Conflict miss on a dirty line.
        access(32'h444, 32'd0, 1'b1, 1'b0);
        check("wb_addr", 256'(last_wb_addr), 256'(32'h40));
        check("wb_word1", 256'(last_wb_data[63:32]), 256'(32'hDEAD_BEEF));
        check("refill_addr", 256'(last_rd_addr), 256'(32'h440));
        check("wb_count", 256'(wb_count), 256'(1));

        // Read+write together is a store; misaligned load matches aligned.
        access(32'h444, 32'h5, 1'b1, 1'b1);
        access(32'h444, 32'd0, 1'b1, 1'b0);
        access(32'h442, 32'd0, 1'b1, 1'b0);
        access(32'h440, 32'd0, 1'b1, 1'b0);

        // Reset while allocating: request drops at once, late ack is ignored.
        p1_addr_i = 32'h840; p1_MemRead_i = 1'b1;
        cyc = 0;
        while (!(mem_enable_o && !mem_write_o) && cyc < 200) begin
            @(negedge clk_i);
            cyc++;
        end
        check("reach_allocate", 256'(cyc < 200), 256'(1));
        #1;
        rst_i = 1'b1; p1_MemRead_i = 1'b0;
        #1;
        check("abort_mem_enable", 256'(mem_enable_o), 256'(0));
        check("abort_mem_write", 256'(mem_write_o), 256'(0));
        check("abort_mem_addr", 256'(mem_addr_o), 256'(0));
        reset_model();
        @(posedge clk_i); #1;
        rst_i = 1'b0;
        repeat (mem_lat + 4) begin
            @(negedge clk_i);
            check("post_abort_idle", 256'(mem_enable_o), 256'(0));
        end
        @(posedge clk_i); #1;
        access(32'h40, 32'd0, 1'b1, 1'b0);

        // Randomized mix over 4 tags x 8 indices to force conflicts and write-backs.
        for (int n = 0; n < 300; n++) begin
            logic [31:0] a;
            int          op;
            a = $urandom();
            a[31:12] = 20'd0;
            a[9:8]   = 2'd0;
            op = int'($urandom_range(0, 99));
            mem_lat = int'($urandom_range(1, 5));
            access(a, $urandom(), (op < 50) || (op >= 85), op >= 50);
            repeat ($urandom_range(0, 2)) begin
                @(posedge clk_i); #1;
            end
        end

        repeat (8) @(posedge clk_i);
        #1;
        check("scoreboard_drained", 256'(exp_q.size()), 256'(0));
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, checks %0d errors %0d", checks, errors);
        $fatal(1, "timeout");
    end
endmodule
